// File: rtl/fmac2fib_rxctrl_wide.sv
// RX control moving packets from the FMAC IPCS/data FIFOs into the fabric data and count FIFOs.
// Per packet: one IPCS read, ceil(bcnt/BPW) data reads, then one count-word write (or a counted drop).
module fmac2fib_rxctrl_wide #(
    parameter int DATA_WIDTH = 64,
    parameter int BCNT_WIDTH = 32,
    parameter int BCNT_MSB   = 63,
    parameter int MAX_BYTES  = 9600,
    parameter int FREE_W     = 10
) (
    input  logic                  clk_fib,
    input  logic                  reset,
    input  logic                  fib_rx_mac_data_empty,
    input  logic [DATA_WIDTH-1:0] fib_rx_mac_pkt_data,
    input  logic                  fib_rx_mac_ipcs_empty,
    input  logic [DATA_WIDTH-1:0] fib_rx_mac_ipcs_data,
    output logic                  fib_rx_mac_rd,
    output logic                  fib_rx_mac_ipcs_rd,
    input  logic [FREE_W-1:0]     rf_free,
    input  logic                  rcf_full,
    input  logic                  drop_en,
    output logic                  wren_rf,
    output logic [DATA_WIDTH-1:0] datain_rf,
    output logic                  wren_rcf,
    output logic [BCNT_WIDTH-1:0] datain_rcf,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           drop_cnt,
    output logic [5:0]            ar_state
);

    localparam int BPW      = DATA_WIDTH / 8;
    localparam int LOG2_BPW = $clog2(BPW);
    localparam int CMP_W    = (FREE_W > 17) ? FREE_W : 17;
    localparam logic [16:0] MAX_B = 17'(MAX_BYTES);

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_READCNT = 6'b000010,
        S_EVAL    = 6'b000100,
        S_RDDATA  = 6'b001000,
        S_DRAIN   = 6'b010000,
        S_DONE    = 6'b100000
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [15:0]             bcnt_r;
    logic [16:0]             remaining_r;
    logic                    rd_d1_r;
    logic                    wren_rf_r;
    logic [DATA_WIDTH-1:0]   datain_rf_r;
    logic                    wren_rcf_r;
    logic [BCNT_WIDTH-1:0]   datain_rcf_r;
    logic [31:0]             pkt_cnt_r;
    logic [31:0]             drop_cnt_r;

    logic                    rd_s;
    logic                    ipcs_rd_s;
    logic                    deliver_evt_s;
    logic                    drop_evt_s;
    logic [15:0]             ipcs_bcnt_s;
    logic [16:0]             ipcs_words_s;
    logic [CMP_W-1:0]        words_cmp_s;
    logic [CMP_W-1:0]        free_cmp_s;
    logic                    unused_ipcs_s;

    // Word count is formed at 17 bits so a 16'hFFFF byte count cannot wrap.
    assign ipcs_bcnt_s   = fib_rx_mac_ipcs_data[BCNT_MSB -: 16];
    assign ipcs_words_s  = ({1'b0, ipcs_bcnt_s} + 17'(BPW - 1)) >> LOG2_BPW;
    assign words_cmp_s   = CMP_W'(remaining_r);
    assign free_cmp_s    = CMP_W'(rf_free);
    assign unused_ipcs_s = ^fib_rx_mac_ipcs_data;

    // Next-state and read-strobe decode; reads are suppressed while reset is held.
    always_comb begin
        state_nxt_s   = state_r;
        rd_s          = 1'b0;
        ipcs_rd_s     = 1'b0;
        deliver_evt_s = 1'b0;
        drop_evt_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!fib_rx_mac_ipcs_empty && !fib_rx_mac_data_empty && !rcf_full && !reset) begin
                    ipcs_rd_s   = 1'b1;
                    state_nxt_s = S_READCNT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_READCNT: state_nxt_s = S_EVAL;
            S_EVAL: begin
                if (bcnt_r == 16'd0) begin
                    state_nxt_s = S_DONE;
                    drop_evt_s  = 1'b1;
                end else if ({1'b0, bcnt_r} > MAX_B) begin
                    state_nxt_s = S_DRAIN;
                end else if (words_cmp_s > free_cmp_s) begin
                    state_nxt_s = drop_en ? S_DRAIN : S_EVAL;
                end else begin
                    state_nxt_s = S_RDDATA;
                end
            end
            S_RDDATA, S_DRAIN: begin
                rd_s = (remaining_r != 17'd0) && !fib_rx_mac_data_empty && !reset;
                if ((remaining_r == 17'd0) && !rd_d1_r) begin
                    state_nxt_s   = S_DONE;
                    deliver_evt_s = (state_r == S_RDDATA);
                    drop_evt_s    = (state_r == S_DRAIN);
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register plus byte-count capture and remaining-word countdown.
    always_ff @(posedge clk_fib) begin
        if (reset) begin
            state_r     <= S_IDLE;
            bcnt_r      <= 16'd0;
            remaining_r <= 17'd0;
            rd_d1_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            rd_d1_r <= rd_s;
            if (state_r == S_READCNT) begin
                bcnt_r      <= ipcs_bcnt_s;
                remaining_r <= ipcs_words_s;
            end else if (rd_s) begin
                remaining_r <= remaining_r - 17'd1;
            end
        end
    end

    // Write path: data is valid the cycle after rd and is written one cycle later.
    always_ff @(posedge clk_fib) begin
        if (reset) begin
            wren_rf_r    <= 1'b0;
            datain_rf_r  <= '0;
            wren_rcf_r   <= 1'b0;
            datain_rcf_r <= '0;
        end else begin
            wren_rf_r  <= rd_d1_r && (state_r == S_RDDATA);
            wren_rcf_r <= deliver_evt_s;
            if (rd_d1_r && (state_r == S_RDDATA)) begin
                datain_rf_r <= fib_rx_mac_pkt_data;
            end
            if (deliver_evt_s) begin
                datain_rcf_r <= {bcnt_r, {(BCNT_WIDTH-16){1'b0}}};
            end
        end
    end

    // Delivered and dropped packet counters; both wrap.
    always_ff @(posedge clk_fib) begin
        if (reset) begin
            pkt_cnt_r  <= 32'd0;
            drop_cnt_r <= 32'd0;
        end else begin
            if (deliver_evt_s) begin
                pkt_cnt_r <= pkt_cnt_r + 32'd1;
            end
            if (drop_evt_s) begin
                drop_cnt_r <= drop_cnt_r + 32'd1;
            end
        end
    end

    assign fib_rx_mac_rd      = rd_s;
    assign fib_rx_mac_ipcs_rd = ipcs_rd_s;
    assign wren_rf            = wren_rf_r;
    assign datain_rf          = datain_rf_r;
    assign wren_rcf           = wren_rcf_r;
    assign datain_rcf         = datain_rcf_r;
    assign pkt_cnt            = pkt_cnt_r;
    assign drop_cnt           = drop_cnt_r;
    assign ar_state           = state_r;

endmodule

// File: tb/tb_fmac2fib_rxctrl_wide.sv
// Scoreboard bench for fmac2fib_rxctrl_wide (64-bit build): FIFO models feed packets,
// a packet-level reference model queues the expected writes, a negedge monitor checks them.
module tb_fmac2fib_rxctrl_wide;

    localparam int DW   = 64;
    localparam int BW   = 32;
    localparam int MAXB = 9600;
    localparam int FW   = 10;
    localparam int BPW  = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          data_empty;
    logic [DW-1:0] pkt_data;
    logic          ipcs_empty;
    logic [DW-1:0] ipcs_data;
    logic          mac_rd;
    logic          ipcs_rd;
    logic [FW-1:0] rf_free;
    logic          rcf_full;
    logic          drop_en;
    logic          wren_rf;
    logic [DW-1:0] datain_rf;
    logic          wren_rcf;
    logic [BW-1:0] datain_rcf;
    logic [31:0]   pkt_cnt;
    logic [31:0]   drop_cnt;
    logic [5:0]    ar_state;

    always #5 clk = ~clk;

    fmac2fib_rxctrl_wide #(
        .DATA_WIDTH(DW), .BCNT_WIDTH(BW), .BCNT_MSB(63), .MAX_BYTES(MAXB), .FREE_W(FW)
    ) dut (
        .clk_fib(clk), .reset(reset),
        .fib_rx_mac_data_empty(data_empty), .fib_rx_mac_pkt_data(pkt_data),
        .fib_rx_mac_ipcs_empty(ipcs_empty), .fib_rx_mac_ipcs_data(ipcs_data),
        .fib_rx_mac_rd(mac_rd), .fib_rx_mac_ipcs_rd(ipcs_rd),
        .rf_free(rf_free), .rcf_full(rcf_full), .drop_en(drop_en),
        .wren_rf(wren_rf), .datain_rf(datain_rf),
        .wren_rcf(wren_rcf), .datain_rcf(datain_rcf),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .ar_state(ar_state)
    );

    typedef struct packed {
        logic        k;   // 0 = data word, 1 = count word
        logic [63:0] v;
    } exp_t;

    exp_t          exp_q[$];
    logic [63:0]   data_q[$];
    logic [63:0]   ipcs_q[$];
    int            tests = 0;
    int            fails = 0;
    int            exp_pkt = 0, exp_drop = 0, exp_rd = 0;
    int            rd_count = 0, rf_seen = 0;
    bit            toggle_mode = 1'b0;
    bit            tgl = 1'b0;
    exp_t          mon_e;
    logic [64:0]   mon_got;

    // FMAC FIFO models: registered read data and empty flags, updated on the read edge.
    always @(posedge clk) begin
        if (reset) begin
            data_empty <= 1'b1;
            ipcs_empty <= 1'b1;
            pkt_data   <= '0;
            ipcs_data  <= '0;
        end else begin
            if (mac_rd && data_q.size() > 0) pkt_data <= data_q.pop_front();
            if (ipcs_rd && ipcs_q.size() > 0) ipcs_data <= ipcs_q.pop_front();
            tgl = ~tgl;
            data_empty <= (data_q.size() == 0) || (toggle_mode && tgl);
            ipcs_empty <= (ipcs_q.size() == 0);
        end
    end

    // Monitor: compare every fabric-side write against the scoreboard in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (mac_rd) begin
                rd_count++;
                if (data_empty) begin
                    fails++;
                    $display("FAIL rd_when_empty: rd=1 while data_empty=1 at %0t", $time);
                end
            end
            if (wren_rf || wren_rcf) begin
                tests++;
                mon_got = wren_rcf ? {1'b1, 32'h0, datain_rcf} : {1'b0, datain_rf};
                if (wren_rf && wren_rcf) begin
                    fails++;
                    $display("FAIL both_wren: wren_rf and wren_rcf together at %0t", $time);
                end else if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: got %h, expected no write", mon_got);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_got !== mon_e) begin
                        fails++;
                        $display("FAIL write_data: got %h expected %h", mon_got, mon_e);
                    end
                end
                if (wren_rf) rf_seen++;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: decide the packet's fate from its byte count and the space it will see.
    task automatic push_pkt(input int bcnt, input int free_eff);
        int          words;
        bit          deliver;
        logic [63:0] w;
        exp_t        e;
        words   = (bcnt + BPW - 1) / BPW;
        deliver = (bcnt != 0) && (bcnt <= MAXB) && (words <= free_eff);
        for (int i = 0; i < words; i++) begin
            w = {$urandom(), $urandom()};
            data_q.push_back(w);
            if (deliver) begin
                e.k = 1'b0; e.v = w;
                exp_q.push_back(e);
            end
        end
        if (deliver) begin
            e.k = 1'b1; e.v = {32'h0, bcnt[15:0], 16'h0};
            exp_q.push_back(e);
            exp_pkt++;
        end else begin
            exp_drop++;
        end
        exp_rd += words;
        w = {$urandom(), $urandom()};
        w[63:48] = bcnt[15:0];
        ipcs_q.push_back(w);
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n;
        bit done;
        n = 0; done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            if (data_q.size() == 0 && ipcs_q.size() == 0 && exp_q.size() == 0 &&
                ar_state == 6'd1 && data_empty && ipcs_empty) done = 1'b1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s_timeout: got busy after %0d cycles, expected idle", name, n);
        end
        chk({name, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkt));
        chk({name, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
        chk({name, "_rd_count"}, 64'(rd_count), 64'(exp_rd));
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_rd"}, 64'(mac_rd), 64'd0);
        chk({name, "_ipcs_rd"}, 64'(ipcs_rd), 64'd0);
        chk({name, "_wren"}, 64'({wren_rf, wren_rcf}), 64'd0);
        chk({name, "_datain_rf"}, datain_rf, 64'd0);
        chk({name, "_datain_rcf"}, 64'(datain_rcf), 64'd0);
        chk({name, "_cnts"}, {pkt_cnt, drop_cnt}, 64'd0);
        chk({name, "_state"}, 64'(ar_state), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        data_q.delete(); ipcs_q.delete(); exp_q.delete();
        exp_pkt = 0; exp_drop = 0; exp_rd = 0; rd_count = 0; rf_seen = 0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int r;
        reset = 1'b1; rf_free = 10'd100; rcf_full = 1'b0; drop_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        reset = 1'b0;
        @(negedge clk);

        // Basic 60-byte packet: 8 words, count word 32'h003C0000.
        push_pkt(60, 100);
        wait_quiet("bcnt60", 200);

        // Odd sizes and back-to-back packets.
        push_pkt(65, 100); push_pkt(8, 100); push_pkt(1, 100); push_pkt(16, 100);
        wait_quiet("b2b", 300);

        // Oversize drain, then zero-length drop followed by a normal packet.
        push_pkt(9601, 100);
        wait_quiet("oversize", 3000);
        push_pkt(0, 100); push_pkt(16, 100);
        wait_quiet("zero_len", 200);

        // Not enough space with drop_en=0 holds in EVAL until space appears.
        rf_free = 10'd4;
        push_pkt(64, 8);
        repeat (30) @(negedge clk);
        chk("hold_state", 64'(ar_state), 64'd4);
        chk("hold_no_rd", 64'(rd_count), 64'(exp_rd - 8));
        rf_free = 10'd8;
        wait_quiet("hold_release", 200);

        // Same shortage with drop_en=1 drains and drops.
        drop_en = 1'b1; rf_free = 10'd4;
        push_pkt(64, 4);
        wait_quiet("space_drop", 200);

        // Empty flag toggling during the data phase.
        rf_free = 10'd100; toggle_mode = 1'b1;
        push_pkt(64, 100);
        wait_quiet("toggle_empty", 300);
        toggle_mode = 1'b0;

        // Reset in the middle of a packet, then a normal packet.
        rf_seen = 0;
        push_pkt(64, 100);
        n = 0;
        while (rf_seen < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_pkt_words_seen", 64'(rf_seen >= 3), 64'd1);
        do_reset();
        push_pkt(24, 100);
        wait_quiet("after_reset", 200);

        // Randomised traffic with space-based drops and boundary sizes around rf_free.
        drop_en = 1'b1; rf_free = 10'd30;
        for (int p = 0; p < 40; p++) begin
            r = int'($urandom_range(0, 19));
            toggle_mode = ($urandom_range(0, 3) == 0);
            case (r)
                0:       push_pkt(0, 30);
                1:       push_pkt(9601 + int'($urandom_range(0, 50)), 30);
                2:       push_pkt(240, 30);
                3:       push_pkt(241, 30);
                default: push_pkt(int'($urandom_range(1, 320)), 30);
            endcase
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        toggle_mode = 1'b0;
        push_pkt(100, 30);
        wait_quiet("random", 40000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
